norm_shift: RTL and testbench
=============================

# norm_shift

Iterative normalizer, the counterpart to the leading-one/leading-zero counter. The counter only measures the run of leading bits; this block applies it. It counts the leading run of `one_or_zero` bits in a 32-bit operand and shifts that run out, returning both the shifted value and the count. It serves multi-cycle datapath ops (soft-float normalization, CLZ/CLO-backed shifts) next to the ALU. The search is binary over five steps (16/8/4/2/1), one step per clock, behind a start/busy/done handshake.

## Interface
- WIDTH, 32, operand width. Only 32 is supported.
- CW, 6, count width, equal to log2(WIDTH)+1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request. Sampled only when busy=0.
- data  in  32  operand, captured on an accepted start.
- one_or_zero  in  1  polarity of the run: 1 counts leading ones, 0 counts leading zeros. Captured with data.
- busy  out  1  high while a search is in progress.
- done  out  1  one-cycle pulse when result/count are valid.
- result  out  32  data shifted left by count, zero-filled.
- count  out  6  length of the leading run, 0..32.

## Operation
- States: IDLE, RUN, DONE. Step index `step` is 3 bits, 0..4, and maps to widths 16, 8, 4, 2, 1.
- Accept rule: in IDLE or DONE with start=1:
  - load sh_reg ← data;
  - load pol ← one_or_zero;
  - cnt ← 0, step ← 0;
  - all_eq ← (data == {32{one_or_zero}});
  - go to RUN.
- RUN, at step k with width w:
  - if sh_reg[31:32-w] == {w{pol}}: sh_reg ← sh_reg << w and cnt ← cnt + w;
  - otherwise hold sh_reg and cnt.
  - step ← step+1. After step 4, go to DONE.
- Entering DONE:
  - if all_eq: result ← 0, count ← 32;
  - else: result ← sh_reg, count ← cnt (0..31).
- DONE lasts one cycle with done=1. It returns to IDLE unless start=1, in which case it goes straight to RUN with the new operand.
- result and count hold their last values until the next DONE or reset.
- start while busy=1 is ignored: no queueing and no effect on the current search.
- Width rule: cnt never exceeds 31 in RUN (16+8+4+2+1). The value 32 only comes from all_eq.
- Reset, including mid-RUN: state IDLE, busy=0, done=0, result=0, count=0, internal registers cleared. An aborted search produces no done.

## Timing
- Start accepted at the edge ending cycle T.
- busy=1 during cycles T+1..T+5.
- done=1 during cycle T+6, with result/count valid in the same cycle.
- Fixed latency: 6 cycles from start to done, independent of data.
- Throughput: one operation per 6 cycles, because start in the DONE cycle is accepted.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `norm_pkg`:
  - state enum (IDLE, RUN, DONE);
  - step-width constant array {16, 8, 4, 2, 1};
  - WIDTH/CW defaults.
- One sub-module is natural: `norm_stage`, combinational. It takes the current value, polarity and width w, and returns a match flag and the shifted value. It is instantiated once, with w muxed by step.
- The FSM, cnt accumulator and output registers live in norm_shift.

## Test plan
- data=0x0000_0F00, one_or_zero=0, start at T → done at T+6, count=20, result=0xF000_0000; busy high T+1..T+5.
- data=0xFFF0_1234, one_or_zero=1 → count=12, result=0x0123_4000.
- Polarity boundaries:
  - data=0xFFFF_FFFF, one_or_zero=1 → count=32, result=0x0000_0000;
  - data=0x0000_0000, one_or_zero=0 → count=32, result=0;
  - data=0x8000_0000, one_or_zero=0 → count=0, result=0x8000_0000.
- Start pulsed at T+2 with different data while busy → ignored; first result unchanged at T+6. A start held in the DONE cycle (T+6) → second done at T+12 with correct values.
- rst asserted in cycle T+3 → from T+4: busy=0, done=0, result=0, count=0, and no done pulse follows.

Source files
------------

// File: rtl/norm_pkg.sv
// Shared types and constants for the iterative leading-run normalizer.
// The binary search uses step widths 16, 8, 4, 2, 1, applied one per clock.
package norm_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CW    = 6;
  localparam int STEPS     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [DEF_CW-1:0] STEP_WIDTH [STEPS] = '{6'd16, 6'd8, 6'd4, 6'd2, 6'd1};

  // Out-of-range steps map to width 0, which leaves the operand untouched.
  function automatic logic [DEF_CW-1:0] step_width(input logic [2:0] step);
    logic [DEF_CW-1:0] w;
    w = '0;
    for (int i = 0; i < STEPS; i++) begin
      if (step == 3'(i)) w = STEP_WIDTH[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/norm_stage.sv
// One combinational search step: tests whether the top w bits all equal the
// polarity and provides the operand shifted left by w.
module norm_stage
  import norm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic [WIDTH-1:0] value,
  input  logic             pol,
  input  logic [CW-1:0]    w,
  output logic             match,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] eq_bits;
  logic [WIDTH-1:0] top_mask;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_eq
      assign eq_bits[gi] = (value[gi] == pol);
    end
  endgenerate

  // Ones in the top w bit positions only; the bits outside it are don't-care.
  assign top_mask = ~({WIDTH{1'b1}} >> w);
  assign match    = &(eq_bits | ~top_mask);
  assign shifted  = value << w;

endmodule

// File: rtl/norm_shift.sv
// Iterative normalizer: counts the leading run of one_or_zero bits and shifts
// it out over five clocks, with a start/busy/done handshake and registered outputs.
module norm_shift
  import norm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CW    = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic             one_or_zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    count
);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic [2:0]       step_reg;
  logic             pol_reg;
  logic             all_eq_reg;
  logic [WIDTH-1:0] result_reg;
  logic [CW-1:0]    count_reg;

  logic             accept;
  logic             last_step;
  logic [CW-1:0]    stage_w;
  logic             stage_match;
  logic [WIDTH-1:0] stage_shifted;
  logic [WIDTH-1:0] sh_next;
  logic [CW-1:0]    cnt_next;

  assign accept    = start && (state_reg != RUN);
  assign last_step = (step_reg == LAST_STEP);
  assign stage_w   = step_width(step_reg);

  norm_stage #(
    .WIDTH(WIDTH),
    .CW   (CW)
  ) u_stage (
    .value  (sh_reg),
    .pol    (pol_reg),
    .w      (stage_w),
    .match  (stage_match),
    .shifted(stage_shifted)
  );

  assign sh_next  = stage_match ? stage_shifted : sh_reg;
  assign cnt_next = stage_match ? (cnt_reg + stage_w) : cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg     <= '0;
      cnt_reg    <= '0;
      step_reg   <= '0;
      pol_reg    <= 1'b0;
      all_eq_reg <= 1'b0;
      result_reg <= '0;
      count_reg  <= '0;
    end else if (accept) begin
      sh_reg     <= data;
      pol_reg    <= one_or_zero;
      cnt_reg    <= '0;
      step_reg   <= '0;
      all_eq_reg <= (data == {WIDTH{one_or_zero}});
    end else if (state_reg == RUN) begin
      sh_reg   <= sh_next;
      cnt_reg  <= cnt_next;
      step_reg <= step_reg + 3'd1;
      // The search alone tops out at WIDTH-1, so a full run is taken from all_eq.
      if (last_step) begin
        result_reg <= all_eq_reg ? '0 : sh_next;
        count_reg  <= all_eq_reg ? CW'(WIDTH) : cnt_next;
      end
    end
  end

  assign busy   = (state_reg == RUN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign count  = count_reg;

endmodule

// File: tb/tb_norm_shift.sv
// Self-checking bench for norm_shift: directed vector table, randomized
// operands against a bit-scan reference model, and handshake/reset sequences.
module tb_norm_shift;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data;
  logic        one_or_zero;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [5:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  norm_shift dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data       (data),
    .one_or_zero(one_or_zero),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        p;
    int          exp_count;
    logic [31:0] exp_result;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: scan from the MSB while bits equal the polarity.
  function automatic int model_count(input logic [31:0] d, input logic p);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] != p) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] d, input logic p);
    int n = model_count(d, p);
    if (n >= 32) return 32'h0;
    return d << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation from the IDLE state, checking busy/done timing as well.
  task automatic run_op(input string tag, input logic [31:0] d, input logic p,
                        input int exp_c, input logic [31:0] exp_r);
    logic busy_ok;
    start = 1'b1; data = d; one_or_zero = p;
    tick();
    start = 1'b0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
      tick();
    end
    check({tag, " busy_T1..T5"}, {31'b0, busy_ok}, 32'h1);
    check({tag, " done_T6"}, {31'b0, done}, 32'h1);
    check({tag, " busy_T6"}, {31'b0, busy}, 32'h0);
    check({tag, " count"}, {26'b0, count}, 32'(exp_c));
    check({tag, " result"}, result, exp_r);
    $display("op %s data=%h pol=%0d -> count=%0d result=%h", tag, d, p, count, result);
    tick();
    check({tag, " done_cleared"}, {31'b0, done}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic        p;
    int          n;
    logic        seen_done;

    rst = 1'b1; start = 1'b0; data = '0; one_or_zero = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset result", result, 32'h0);
    check("reset count", {26'b0, count}, 32'h0);
    tick();

    vecs[0] = '{32'h0000_0F00, 1'b0, 20, 32'hF000_0000};
    vecs[1] = '{32'hFFF0_1234, 1'b1, 12, 32'h0123_4000};
    vecs[2] = '{32'hFFFF_FFFF, 1'b1, 32, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 1'b0, 32, 32'h0000_0000};
    vecs[4] = '{32'h8000_0000, 1'b0, 0,  32'h8000_0000};
    vecs[5] = '{32'h7FFF_FFFF, 1'b0, 1,  32'hFFFF_FFFE};
    vecs[6] = '{32'h0000_0001, 1'b0, 31, 32'h8000_0000};
    vecs[7] = '{32'hFFFF_FFFE, 1'b1, 31, 32'h0000_0000};
    vecs[8] = '{32'h0000_0001, 1'b1, 0,  32'h0000_0001};
    vecs[9] = '{32'hFFFF_FFFF, 1'b0, 0,  32'hFFFF_FFFF};
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].p, vecs[i].exp_count, vecs[i].exp_result);

    // Random operands with a forced leading run of random length.
    for (int i = 0; i < 40; i++) begin
      p = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 32);
      d = $urandom;
      for (int b = 0; b < 32; b++)
        if (b >= 32 - n) d[b] = p;
      run_op($sformatf("rnd%0d", i), d, p, model_count(d, p), model_result(d, p));
    end

    // Start while busy is ignored; start in the DONE cycle is accepted.
    start = 1'b1; data = 32'h0000_0F00; one_or_zero = 1'b0;
    tick();                                   // T+1
    start = 1'b0;
    tick();                                   // T+2
    start = 1'b1; data = 32'hFFFF_0000; one_or_zero = 1'b1;
    tick();                                   // T+3
    start = 1'b0;
    check("ign busy_T3", {31'b0, busy}, 32'h1);
    tick(); tick(); tick();                   // T+6
    check("ign done_T6", {31'b0, done}, 32'h1);
    check("ign count", {26'b0, count}, 32'd20);
    check("ign result", result, 32'hF000_0000);
    $display("op ignore-start count=%0d result=%h", count, result);
    start = 1'b1; data = 32'h00FF_0000; one_or_zero = 1'b0;
    tick();                                   // T+7
    start = 1'b0;
    check("b2b busy_T7", {31'b0, busy}, 32'h1);
    check("b2b done_T7", {31'b0, done}, 32'h0);
    check("b2b held count", {26'b0, count}, 32'd20);
    tick(); tick(); tick(); tick();           // T+11
    check("b2b done_T11", {31'b0, done}, 32'h0);
    tick();                                   // T+12
    check("b2b done_T12", {31'b0, done}, 32'h1);
    check("b2b count", {26'b0, count}, 32'd8);
    check("b2b result", result, 32'hFF00_0000);
    $display("op back-to-back count=%0d result=%h", count, result);
    tick();

    // Reset in the middle of a search.
    start = 1'b1; data = 32'h0000_00FF; one_or_zero = 1'b0;
    tick();                                   // T+1
    start = 1'b0;
    tick(); tick();                           // T+3
    rst = 1'b1;
    tick();                                   // T+4
    rst = 1'b0;
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst done", {31'b0, done}, 32'h0);
    check("rst result", result, 32'h0);
    check("rst count", {26'b0, count}, 32'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      tick();
    end
    check("rst no_done", {31'b0, seen_done}, 32'h0);
    $display("op mid-run reset busy=%0d done=%0d count=%0d result=%h", busy, done, count, result);

    run_op("post_rst", 32'h0003_0000, 1'b0, 14, 32'hC000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
